rotate_sdram_sched: RTL

- Sequences SDRAM port traffic for the rotating scandoubler.
- Arbitrates the 16-word write-burst stream (vidin_*) and the 8-word read-burst stream (vidout_*) onto one burst port of the SDRAM controller; the controller performs the cornerturn.
- Generates per-word vidin_ack and vidout_ack.
- Read priority keeps the output linebuffers fed; a starvation limit guarantees write progress.

---
 rtl/rotate_sched_pkg.sv | 30 +++
 rtl/rotate_sched_stats.sv | 52 +++++
 rtl/rotate_sdram_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rotate_sched_pkg.sv
//==============================================================================
// Module : rotate_sched_pkg
// Brief  : Shared types and constants for the rotating-scandoubler SDRAM
//          scheduler (FSM encoding, burst lengths, burst command layout).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rotate_sched_pkg;

    localparam int c_WR_BURST = 16;
    localparam int c_RD_BURST = 8;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_CMD  = 3'd1;
    localparam logic [2:0] c_ST_WR_DATA = 3'd2;
    localparam logic [2:0] c_ST_RD_CMD  = 3'd3;
    localparam logic [2:0] c_ST_RD_DATA = 3'd4;

    typedef struct packed {
        logic       we;
        logic       frame;
        logic [9:0] row;
        logic [9:0] col;
        logic [4:0] len;
    } mem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/rotate_sched_stats.sv
//==============================================================================
// Module : rotate_sched_stats
// Brief  : Saturating write-stall and read-gap cycle counters, cleared on
//          reset and whenever the write frame select toggles.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rotate_sched_stats (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        vidin_req,
    input  logic        vidout_req,
    input  logic        vidin_frame,
    input  logic        in_wr,
    input  logic        in_idle,
    output logic [15:0] stat_wr_stall,
    output logic [15:0] stat_rd_gap
);

    logic        r_frame_q;
    logic [15:0] r_wr_stall;
    logic [15:0] r_rd_gap;
    logic        w_frame_toggle;

    assign w_frame_toggle = (vidin_frame != r_frame_q);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_frame_q  <= 1'b0;
            r_wr_stall <= 16'd0;
            r_rd_gap   <= 16'd0;
        end else begin
            r_frame_q <= vidin_frame;
            if (w_frame_toggle) begin
                r_wr_stall <= 16'd0;
                r_rd_gap   <= 16'd0;
            end else begin
                if (vidin_req && !in_wr && (r_wr_stall != 16'hFFFF))
                    r_wr_stall <= r_wr_stall + 16'd1;
                if (vidout_req && (in_idle || in_wr) && (r_rd_gap != 16'hFFFF))
                    r_rd_gap <= r_rd_gap + 16'd1;
            end
        end
    end

    assign stat_wr_stall = r_wr_stall;
    assign stat_rd_gap   = r_rd_gap;

endmodule

`default_nettype wire

// File: rtl/rotate_sdram_sched.sv
//==============================================================================
// Module : rotate_sdram_sched
// Brief  : Arbitrates write bursts (vidin) and read bursts (vidout) onto one
//          SDRAM burst port; read priority with a write-starvation limit.
//          Optional statistics: define ROTATE_SDRAM_SCHED_STATS_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rotate_sdram_sched
    import rotate_sched_pkg::*;
#(
    parameter int MAX_RD_RUN = 4,
    parameter int RD_BURST   = c_RD_BURST,
    parameter int WR_BURST   = c_WR_BURST
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        vidin_req,
    input  logic        vidin_frame,
    input  logic [9:0]  vidin_row,
    input  logic [9:0]  vidin_col,
    input  logic [15:0] vidin_d,
    output logic        vidin_ack,
    input  logic        vidout_req,
    input  logic        vidout_frame,
    input  logic [9:0]  vidout_row,
    input  logic [9:0]  vidout_col,
    output logic [15:0] vidout_d,
    output logic        vidout_ack,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_we,
    output logic        mem_cmd_frame,
    output logic [9:0]  mem_cmd_row,
    output logic [9:0]  mem_cmd_col,
    output logic [4:0]  mem_cmd_len,
    output logic [15:0] mem_wdata,
    input  logic        mem_wack,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] stat_wr_stall,
    output logic [15:0] stat_rd_gap
);

    localparam int               c_RUN_W   = $clog2(MAX_RD_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_RD_RUN);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);
    localparam logic [4:0]       c_WR_LEN  = 5'(WR_BURST);
    localparam logic [4:0]       c_RD_LEN  = 5'(RD_BURST);

    logic [2:0]         r_state;
    logic [c_RUN_W-1:0] r_rd_run;
    mem_cmd_t           r_cmd;
    logic [4:0]         r_cnt;
    logic               r_rd_pulse;
    logic               r_rd_ack;
    logic [15:0]        r_vidout_d;

    logic w_rd_grant;
    logic w_wr_word;
    logic w_rd_word;
    logic w_unused;

    // Low column bits are implied zero by burst alignment.
    assign w_unused   = ^{vidin_col[3:0], vidout_col[2:0]};

    assign w_rd_grant = vidout_req && (!vidin_req || (r_rd_run < c_RUN_MAX));
    assign w_wr_word  = (r_state == c_ST_WR_DATA) && mem_wack;
    assign w_rd_word  = (r_state == c_ST_RD_DATA) && mem_rvalid && (r_cnt != c_RD_LEN);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_rd_run   <= '0;
            r_cmd      <= '0;
            r_cnt      <= 5'd0;
            r_rd_pulse <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_vidout_d <= 16'd0;
        end else begin
            r_rd_pulse <= 1'b0;
            r_rd_ack   <= 1'b0;
            if (w_rd_word) begin
                r_vidout_d <= mem_rdata;
                r_rd_pulse <= 1'b1;
                r_rd_ack   <= vidout_req;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_rd_grant) begin
                        r_state <= c_ST_RD_CMD;
                        r_cmd   <= '{we: 1'b0, frame: vidout_frame, row: vidout_row,
                                     col: {vidout_col[9:3], 3'b000}, len: c_RD_LEN};
                    end else if (vidin_req) begin
                        r_state <= c_ST_WR_CMD;
                        r_cmd   <= '{we: 1'b1, frame: vidin_frame, row: vidin_row,
                                     col: {vidin_col[9:4], 4'b0000}, len: c_WR_LEN};
                    end
                    // The run only counts reads that actually held off a write.
                    if (vidin_req && w_rd_grant) begin
                        if (r_rd_run != c_RUN_MAX)
                            r_rd_run <= r_rd_run + c_RUN_ONE;
                    end else begin
                        r_rd_run <= '0;
                    end
                end
                c_ST_WR_CMD: begin
                    if (mem_cmd_ready) begin
                        r_state <= c_ST_WR_DATA;
                        r_cnt   <= 5'd0;
                    end
                end
                c_ST_RD_CMD: begin
                    if (mem_cmd_ready) begin
                        r_state <= c_ST_RD_DATA;
                        r_cnt   <= 5'd0;
                    end
                end
                c_ST_WR_DATA: begin
                    if (mem_wack) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == c_WR_LEN - 5'd1)
                            r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RD_DATA: begin
                    if (w_rd_word)
                        r_cnt <= r_cnt + 5'd1;
                    // Leave once the last word's (possibly suppressed) ack has issued.
                    if (r_rd_pulse && (r_cnt == c_RD_LEN))
                        r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_cmd_valid = (r_state == c_ST_WR_CMD) || (r_state == c_ST_RD_CMD);
    assign mem_cmd_we    = r_cmd.we;
    assign mem_cmd_frame = r_cmd.frame;
    assign mem_cmd_row   = r_cmd.row;
    assign mem_cmd_col   = r_cmd.col;
    assign mem_cmd_len   = r_cmd.len;
    assign mem_wdata     = vidin_d;
    assign vidin_ack     = w_wr_word;
    assign vidout_ack    = r_rd_ack;
    assign vidout_d      = r_vidout_d;

`ifdef ROTATE_SDRAM_SCHED_STATS_EN
    logic w_in_wr;
    logic w_in_idle;

    assign w_in_wr   = (r_state == c_ST_WR_CMD) || (r_state == c_ST_WR_DATA);
    assign w_in_idle = (r_state == c_ST_IDLE);

    rotate_sched_stats u_stats (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .vidin_req     (vidin_req),
        .vidout_req    (vidout_req),
        .vidin_frame   (vidin_frame),
        .in_wr         (w_in_wr),
        .in_idle       (w_in_idle),
        .stat_wr_stall (stat_wr_stall),
        .stat_rd_gap   (stat_rd_gap)
    );
`else
    assign stat_wr_stall = 16'd0;
    assign stat_rd_gap   = 16'd0;
`endif

endmodule

`default_nettype wire
